// File: rtl/bitcoin_hash_multi.sv
// bitcoin_hash_multi: double SHA-256 nonce sweep over one 80-byte block header.
// The header is read once and its first-block midstate is reused for every nonce.
// Word H0 of each final digest is written to output memory.
module bitcoin_hash_multi #(
    parameter int          NUM_NONCES  = 16,
    parameter logic [31:0] NONCE_START = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_READ, S_BLK1, S_MID, S_BLK2, S_FIN2, S_BLK3, S_FIN3, S_WRITE
    } state_t;

    localparam logic [15:0] LAST_N = 16'(NUM_NONCES - 1);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [15:0] n_q;
    logic [15:0] msg_base_q;
    logic [15:0] out_base_q;
    logic [31:0] msg_q  [0:18];
    logic [31:0] work_q [0:7];
    logic [31:0] mid_q  [0:7];
    logic [31:0] win_q  [0:15];
    logic        done_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [31:0] wdata_q;

    logic [31:0] t1_d, t2_d, w_new_d, nonce_d;
    logic [31:0] iv_sum_d  [0:7];
    logic [31:0] mid_sum_d [0:7];
    logic [31:0] blk2_d    [0:15];
    logic [31:0] blk3_d    [0:15];
    logic [4:0]  rd_idx;

    // One SHA-256 round: a..h live in work_q[0..7], w_t is the window head.
    assign t1_d = work_q[7] + bsig1(work_q[4]) + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
                + K[cnt_q] + win_q[0];
    assign t2_d = bsig0(work_q[0]) + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));

    // Window holds w_t..w_{t+15}; the new tail is w_{t+16}.
    assign w_new_d = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

    // WRITE preloads the following nonce, every other state uses the current one.
    assign nonce_d = NONCE_START + {16'h0, n_q} + ((state_q == S_WRITE) ? 32'd1 : 32'd0);

    // Header word captured in READ cycle k arrived from the address of cycle k-1.
    assign rd_idx = cnt_q[4:0] - 5'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sum
            assign iv_sum_d[gi]  = IV[gi] + work_q[gi];
            assign mid_sum_d[gi] = mid_q[gi] + work_q[gi];
        end
        for (gi = 0; gi < 16; gi++) begin : g_blk
            if (gi < 3) begin : g_b2_msg
                assign blk2_d[gi] = msg_q[16 + gi];
            end else if (gi == 3) begin : g_b2_nonce
                assign blk2_d[gi] = nonce_d;
            end else if (gi == 4) begin : g_b2_pad
                assign blk2_d[gi] = 32'h80000000;
            end else if (gi == 15) begin : g_b2_len
                assign blk2_d[gi] = 32'h00000280;
            end else begin : g_b2_zero
                assign blk2_d[gi] = 32'h0;
            end

            if (gi < 8) begin : g_b3_hash
                assign blk3_d[gi] = mid_sum_d[gi];
            end else if (gi == 8) begin : g_b3_pad
                assign blk3_d[gi] = 32'h80000000;
            end else if (gi == 15) begin : g_b3_len
                assign blk3_d[gi] = 32'h00000100;
            end else begin : g_b3_zero
                assign blk3_d[gi] = 32'h0;
            end
        end
    endgenerate

    // Control FSM, compression datapath and registered memory outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            msg_base_q <= '0;
            out_base_q <= '0;
            done_q     <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < 19; i++) msg_q[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                mid_q[i]  <= '0;
            end
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        msg_base_q <= message_addr;
                        out_base_q <= output_addr;
                        n_q        <= '0;
                        cnt_q      <= '0;
                        mem_addr_q <= message_addr;
                        done_q     <= 1'b0;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    // m[19] is never stored: the nonce replaces it.
                    if (cnt_q != 6'd0 && cnt_q <= 6'd19) msg_q[rd_idx] <= mem_read_data;
                    if (cnt_q < 6'd19) mem_addr_q <= msg_base_q + {10'd0, cnt_q} + 16'd1;
                    if (cnt_q == 6'd20) begin
                        for (int i = 0; i < 16; i++) win_q[i] <= msg_q[i];
                        for (int i = 0; i < 8; i++) work_q[i] <= IV[i];
                        cnt_q   <= '0;
                        state_q <= S_BLK1;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_BLK1, S_BLK2, S_BLK3: begin
                    work_q[0] <= t1_d + t2_d;
                    work_q[1] <= work_q[0];
                    work_q[2] <= work_q[1];
                    work_q[3] <= work_q[2];
                    work_q[4] <= work_q[3] + t1_d;
                    work_q[5] <= work_q[4];
                    work_q[6] <= work_q[5];
                    work_q[7] <= work_q[6];
                    for (int i = 0; i < 15; i++) win_q[i] <= win_q[i + 1];
                    win_q[15] <= w_new_d;
                    // Counter wraps to 0 after round 63, ready for the next block.
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        case (state_q)
                            S_BLK1:  state_q <= S_MID;
                            S_BLK2:  state_q <= S_FIN2;
                            default: state_q <= S_FIN3;
                        endcase
                    end
                end
                S_MID: begin
                    for (int i = 0; i < 8; i++) begin
                        mid_q[i]  <= iv_sum_d[i];
                        work_q[i] <= iv_sum_d[i];
                    end
                    for (int i = 0; i < 16; i++) win_q[i] <= blk2_d[i];
                    state_q <= S_BLK2;
                end
                S_FIN2: begin
                    for (int i = 0; i < 16; i++) win_q[i] <= blk3_d[i];
                    for (int i = 0; i < 8; i++) work_q[i] <= IV[i];
                    state_q <= S_BLK3;
                end
                S_FIN3: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= out_base_q + n_q;
                    wdata_q    <= iv_sum_d[0];
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    if (n_q == LAST_N) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        n_q <= n_q + 16'd1;
                        for (int i = 0; i < 8; i++) work_q[i] <= mid_q[i];
                        for (int i = 0; i < 16; i++) win_q[i] <= blk2_d[i];
                        state_q <= S_BLK2;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done           = done_q;
    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_bitcoin_hash_multi.sv
// Bench for bitcoin_hash_multi: three instances (default sweep, wrap, genesis)
// share one header memory and are checked against a full-schedule SHA-256 model.
module tb_bitcoin_hash_multi;

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV_TB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic        clk;
    logic        reset;
    logic        start_v [3];
    logic        done_w  [3];
    logic        mclk_w  [3];
    logic        we_w    [3];
    logic [15:0] addr_w  [3];
    logic [31:0] wd_w    [3];
    logic [31:0] rd_q    [3];
    logic [31:0] mem     [65536];
    logic [31:0] hdr     [19];
    logic [15:0] maddr_v [3];
    logic [15:0] oaddr_v [3];

    int n_pass = 0;
    int n_total = 0;

    bitcoin_hash_multi #(.NUM_NONCES(16), .NONCE_START(32'h0)) u_dut (
        .clk(clk), .reset(reset), .start(start_v[0]), .message_addr(maddr_v[0]), .output_addr(oaddr_v[0]),
        .done(done_w[0]), .mem_clk(mclk_w[0]), .mem_we(we_w[0]), .mem_addr(addr_w[0]),
        .mem_write_data(wd_w[0]), .mem_read_data(rd_q[0]));

    bitcoin_hash_multi #(.NUM_NONCES(4), .NONCE_START(32'hFFFFFFFE)) u_wrap (
        .clk(clk), .reset(reset), .start(start_v[1]), .message_addr(maddr_v[1]), .output_addr(oaddr_v[1]),
        .done(done_w[1]), .mem_clk(mclk_w[1]), .mem_we(we_w[1]), .mem_addr(addr_w[1]),
        .mem_write_data(wd_w[1]), .mem_read_data(rd_q[1]));

    bitcoin_hash_multi #(.NUM_NONCES(1), .NONCE_START(32'h1dac2b7c)) u_gen (
        .clk(clk), .reset(reset), .start(start_v[2]), .message_addr(maddr_v[2]), .output_addr(oaddr_v[2]),
        .done(done_w[2]), .mem_clk(mclk_w[2]), .mem_we(we_w[2]), .mem_addr(addr_w[2]),
        .mem_write_data(wd_w[2]), .mem_read_data(rd_q[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rd_q[i] <= mem[addr_w[i]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    // Textbook SHA-256 compression with the full 64-word schedule.
    function automatic void sha_compress(input logic [31:0] hin [8], input logic [31:0] blk [16],
                                         output logic [31:0] hout [8]);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[i] = hin[i] + v[i];
    endfunction

    // H0 of SHA256(SHA256(header with nonce)).
    function automatic logic [31:0] golden_h0(input logic [31:0] nonce);
        logic [31:0] blk [16];
        logic [31:0] mid [8];
        logic [31:0] h1 [8];
        logic [31:0] h2 [8];
        for (int i = 0; i < 16; i++) blk[i] = hdr[i];
        sha_compress(IV_TB, blk, mid);
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0] = hdr[16]; blk[1] = hdr[17]; blk[2] = hdr[18]; blk[3] = nonce;
        blk[4] = 32'h80000000; blk[15] = 32'h00000280;
        sha_compress(mid, blk, h1);
        for (int i = 0; i < 16; i++) blk[i] = (i < 8) ? h1[i] : 32'h0;
        blk[8] = 32'h80000000; blk[15] = 32'h00000100;
        sha_compress(IV_TB, blk, h2);
        return h2[0];
    endfunction

    task automatic rand_hdr();
        for (int i = 0; i < 19; i++) hdr[i] = $urandom;
    endtask

    // Header words at base..base+19 (wrapping); word 19 is junk the DUT must ignore.
    task automatic fill_mem(input logic [15:0] base);
        for (int i = 0; i < 20; i++) mem[16'(base + 16'(i))] = (i < 19) ? hdr[i] : $urandom;
    endtask

    // One run on instance sel. k counts cycles with done low; poke_k pulses start mid-run;
    // pre means start is already high, hold leaves start high at the end.
    task automatic run_sweep(input int sel, input logic [15:0] maddr, input logic [15:0] oaddr,
                             input int nn, input logic [31:0] ns, input int poke_k,
                             input bit pre, input bit hold, input string tag);
        int k, nw;
        bit fin;
        logic [31:0] exp_d;
        k = 0; nw = 0; fin = 0;
        maddr_v[sel] = maddr;
        oaddr_v[sel] = oaddr;
        if (!pre) begin
            @(negedge clk);
            start_v[sel] = 1'b1;
        end
        while (!fin) begin
            @(negedge clk);
            if (!hold) start_v[sel] = (k == poke_k);
            if (done_w[sel]) begin
                fin = 1;
            end else begin
                if (we_w[sel]) begin
                    exp_d = golden_h0(ns + 32'(nw));
                    $display("[%s] write n=%0d addr=%h data=%h exp=%h cyc=%0d",
                             tag, nw, addr_w[sel], wd_w[sel], exp_d, k);
                    check_eq({tag, "_waddr"}, 64'(addr_w[sel]), 64'(16'(oaddr + 16'(nw))));
                    check_eq({tag, "_wdata"}, 64'(wd_w[sel]), 64'(exp_d));
                    check_eq({tag, "_wcyc"}, 64'(k), 64'(216 + 131 * nw));
                    nw++;
                end
                k++;
                if (k > 300 + 131 * nn) begin
                    check_eq({tag, "_timeout"}, 64'(k), 64'(86 + 131 * nn));
                    fin = 1;
                end
            end
        end
        check_eq({tag, "_nwrites"}, 64'(nw), 64'(nn));
        check_eq({tag, "_busy"}, 64'(k), 64'(86 + 131 * nn));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nw, nlow;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            maddr_v[i] = 16'h0;
            oaddr_v[i] = 16'h0;
        end
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_done", 64'(done_w[i]), 64'd1);
            check_eq("rst_we", 64'(we_w[i]), 64'd0);
            check_eq("rst_addr", 64'(addr_w[i]), 64'd0);
            check_eq("rst_wdata", 64'(wd_w[i]), 64'd0);
        end
        check_eq("mem_clk", 64'(mclk_w[0]), 64'(clk));
        @(negedge clk);
        reset = 1'b0;

        // Genesis known answer.
        hdr = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
                32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};
        check_eq("genesis_model", 64'(golden_h0(32'h1dac2b7c)), 64'h6fe28c0a);
        fill_mem(16'h0200);
        run_sweep(2, 16'h0200, 16'h0100, 1, 32'h1dac2b7c, -1, 0, 0, "genesis");

        // Default sweep.
        rand_hdr();
        fill_mem(16'h1000);
        run_sweep(0, 16'h1000, 16'h2000, 16, 32'h0, -1, 0, 0, "sweep");

        // Address and nonce wrap.
        rand_hdr();
        fill_mem(16'hFFF0);
        run_sweep(1, 16'hFFF0, 16'hFFFE, 4, 32'hFFFFFFFE, -1, 0, 0, "wrap");

        // Reset during BLK3 of nonce 2 (cycles 413..476).
        rand_hdr();
        fill_mem(16'h3000);
        maddr_v[0] = 16'h3000;
        oaddr_v[0] = 16'h4000;
        @(negedge clk);
        start_v[0] = 1'b1;
        k = 0; nw = 0;
        while (k < 450) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (we_w[0]) nw++;
            k++;
        end
        reset = 1'b1;
        #1;
        check_eq("rstmid_done", 64'(done_w[0]), 64'd1);
        check_eq("rstmid_we", 64'(we_w[0]), 64'd0);
        check_eq("rstmid_prior_writes", 64'(nw), 64'd2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nw = 0; nlow = 0;
        repeat (300) begin
            @(negedge clk);
            if (we_w[0]) nw++;
            if (!done_w[0]) nlow++;
        end
        check_eq("rstmid_no_writes", 64'(nw), 64'd0);
        check_eq("rstmid_stays_idle", 64'(nlow), 64'd0);
        run_sweep(0, 16'h3000, 16'h4000, 16, 32'h0, -1, 0, 0, "after_rst");

        // Start pulsed during BLK2 of nonce 0.
        rand_hdr();
        fill_mem(16'h5000);
        run_sweep(0, 16'h5000, 16'h6000, 16, 32'h0, 100, 0, 0, "busy_start");

        // Back-to-back runs with start held high.
        rand_hdr();
        fill_mem(16'h7000);
        run_sweep(0, 16'h7000, 16'h8000, 16, 32'h0, -1, 0, 1, "b2b_first");
        run_sweep(0, 16'h7000, 16'h8000, 16, 32'h0, -1, 1, 0, "b2b_second");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
